// File: rtl/key_debounce_scheduler_if.sv
// Key edge inputs and debounced outputs of the shared-timer key debounce scheduler.
// master drives the edge pulses; slave is the scheduler itself.
interface key_debounce_scheduler_if;
   logic [3:0] H2L_Sig;
   logic [3:0] L2H_Sig;
   logic [3:0] Press_Pulse;
   logic [3:0] Release_Pulse;
   logic [3:0] LED_Out;
   logic       Busy;
   logic [1:0] Grant_Idx;
   logic       state_dbg;

   // Edge pulses are one-cycle strobes with no back-pressure: an edge is captured
   // in the cycle it is presented and never refused (it merges into a pending flag).
   modport master (
      output H2L_Sig, L2H_Sig,
      input  Press_Pulse, Release_Pulse, LED_Out, Busy, Grant_Idx, state_dbg
   );

   modport slave (
      input  H2L_Sig, L2H_Sig,
      output Press_Pulse, Release_Pulse, LED_Out, Busy, Grant_Idx, state_dbg
   );
endinterface

// File: rtl/key_debounce_scheduler.sv
// Four key channels share one ms timer: pending edges are granted round-robin and
// debounced one at a time. Define KEY_SCHED_RELEASE_EN to also debounce releases.
module key_debounce_scheduler #(
   parameter logic [15:0] T1MS     = 16'd49_999,
   parameter logic [3:0]  DELAY_MS = 4'd10
) (
   input logic                     CLK,
   input logic                     RSTn,
   key_debounce_scheduler_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t     state;
   logic [15:0] count1;
   logic [3:0]  count_ms;
   logic [3:0]  pend_p;
   logic [3:0]  pend_r;
   logic [1:0]  grant_idx;
   logic        evt_press;
   logic [3:0]  press_pulse;
   logic [3:0]  led;
   logic        sel_found;
   logic        sel_press;
   logic [1:0]  sel_idx;
   logic [1:0]  cand;
   logic [3:0]  clr_p;
   logic        window_done;

   assign window_done = (count_ms == (DELAY_MS - 4'd1)) && (count1 == T1MS);

   // Round-robin search starting just after the last granted key; press beats release.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = grant_idx;
      sel_press = 1'b0;
      cand      = grant_idx;
      for (int i = 1; i <= 4; i++) begin
         cand = grant_idx + 2'(i);
         if (!sel_found && (pend_p[cand] || pend_r[cand])) begin
            sel_found = 1'b1;
            sel_idx   = cand;
            sel_press = pend_p[cand];
         end
      end
   end

   always_comb begin
      clr_p = '0;
      if (state == IDLE && sel_found && sel_press) clr_p[sel_idx] = 1'b1;
   end

`ifdef KEY_SCHED_RELEASE_EN
   logic [3:0] clr_r;
   logic [3:0] release_pulse;

   always_comb begin
      clr_r = '0;
      if (state == IDLE && sel_found && !sel_press) clr_r[sel_idx] = 1'b1;
   end

   // A new edge in the same cycle as its grant re-arms the flag (set beats clear).
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         pend_r        <= '0;
         release_pulse <= '0;
      end else begin
         pend_r        <= (pend_r & ~clr_r) | bus.L2H_Sig;
         release_pulse <= '0;
         if (state == WAIT && window_done && !evt_press)
            release_pulse[grant_idx] <= 1'b1;
      end
   end

   assign bus.Release_Pulse = release_pulse;
`else
   logic unused_l2h;

   assign unused_l2h        = ^bus.L2H_Sig;
   assign pend_r            = '0;
   assign bus.Release_Pulse = '0;
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state       <= IDLE;
         count1      <= '0;
         count_ms    <= '0;
         pend_p      <= '0;
         grant_idx   <= 2'd3;
         evt_press   <= 1'b1;
         press_pulse <= '0;
         led         <= '0;
      end else begin
         press_pulse <= '0;
         pend_p      <= (pend_p & ~clr_p) | bus.H2L_Sig;
         case (state)
            IDLE: begin
               count1   <= '0;
               count_ms <= '0;
               if (sel_found) begin
                  grant_idx <= sel_idx;
                  evt_press <= sel_press;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (window_done) begin
                  state    <= IDLE;
                  count1   <= '0;
                  count_ms <= '0;
                  if (evt_press) begin
                     press_pulse[grant_idx] <= 1'b1;
                     led[grant_idx]         <= ~led[grant_idx];
                  end
               end else if (count1 == T1MS) begin
                  count1   <= '0;
                  count_ms <= count_ms + 4'd1;
               end else begin
                  count1 <= count1 + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Press_Pulse = press_pulse;
   assign bus.LED_Out     = led;
   assign bus.Busy        = (state == WAIT);
   assign bus.Grant_Idx   = grant_idx;
   assign bus.state_dbg   = (state == WAIT);

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// Bench for key_debounce_scheduler with T1MS=4, DELAY_MS=2 (10-cycle windows):
// directed scenarios with literal expectations plus randomized edges against a model.
module tb_key_debounce_scheduler;
   localparam int WIN = 10;

   logic clk;
   logic rstn;
   int   cyc;
   int   base;
   int   total;
   int   bad;

   key_debounce_scheduler_if bus();

   key_debounce_scheduler #(.T1MS(16'd4), .DELAY_MS(4'd2)) dut (
      .CLK(clk),
      .RSTn(rstn),
      .bus(bus)
   );

   // ---------------- clock / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [3:0] pp;
      logic [3:0] pr;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] led;
      logic       busy;
      logic       is_press;
      logic [1:0] grant;
      int         left;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t model_reset();
      mstate_t s;
      s.pp = '0; s.pr = '0; s.press = '0; s.rel = '0; s.led = '0;
      s.busy = 1'b0; s.is_press = 1'b1; s.grant = 2'd3; s.left = 0;
      return s;
   endfunction

   function automatic mstate_t model_step(mstate_t s, logic [3:0] h, logic [3:0] l);
      mstate_t n = s;
      bit found = 0;
      n.press = '0;
      n.rel   = '0;
      if (n.busy) begin
         n.left = n.left - 1;
         if (n.left == 0) begin
            n.busy = 1'b0;
            if (n.is_press) begin
               n.press[n.grant] = 1'b1;
               n.led[n.grant]   = ~n.led[n.grant];
            end else begin
               n.rel[n.grant] = 1'b1;
            end
         end
      end else begin
         for (int i = 1; i <= 4; i++) begin
            int k = (int'(s.grant) + i) % 4;
            if (!found && (n.pp[k] || n.pr[k])) begin
               found      = 1;
               n.grant    = 2'(k);
               n.is_press = n.pp[k];
               if (n.pp[k]) n.pp[k] = 1'b0;
               else         n.pr[k] = 1'b0;
            end
         end
         if (found) begin
            n.busy = 1'b1;
            n.left = WIN;
         end
      end
      n.pp = n.pp | h;
`ifdef KEY_SCHED_RELEASE_EN
      n.pr = n.pr | l;
`else
      n.pr = n.pr & ~l & 4'b0000;
`endif
      return n;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) m <= model_reset();
      else       m <= model_step(m, bus.H2L_Sig, bus.L2H_Sig);
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("cmp_press", 32'(bus.Press_Pulse), 32'(m.press));
      check("cmp_release", 32'(bus.Release_Pulse), 32'(m.rel));
      check("cmp_led", 32'(bus.LED_Out), 32'(m.led));
      check("cmp_busy", 32'(bus.Busy), 32'(m.busy));
      check("cmp_grant", 32'(bus.Grant_Idx), 32'(m.grant));
      check("cmp_state_dbg", 32'(bus.state_dbg), 32'(m.busy));
      check("onehot_pulse", 32'($countones(bus.Press_Pulse | bus.Release_Pulse) <= 1), 32'd1);
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rstn = 1'b0;
      bus.H2L_Sig = '0;
      bus.L2H_Sig = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_press", 32'(bus.Press_Pulse), 32'd0);
      check("rst_release", 32'(bus.Release_Pulse), 32'd0);
      check("rst_led", 32'(bus.LED_Out), 32'd0);
      check("rst_grant", 32'(bus.Grant_Idx), 32'd3);
   endtask

   task automatic start_test();
      @(posedge clk);
      #1 base = cyc;
   endtask

   task automatic drive_at(input int k, input logic [3:0] h, input logic [3:0] l);
      while (cyc - base < k) begin
         @(posedge clk);
         #1;
      end
      bus.H2L_Sig = h;
      bus.L2H_Sig = l;
      @(posedge clk);
      #1;
      bus.H2L_Sig = '0;
      bus.L2H_Sig = '0;
   endtask

   task automatic wait_cyc(input int k);
      do @(negedge clk); while (cyc - base < k);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      base  = 0;
      rstn  = 1'b0;
      bus.H2L_Sig = '0;
      bus.L2H_Sig = '0;

      // single press on key 0
      do_reset();
      start_test();
      drive_at(0, 4'b0001, 4'b0000);
      wait_cyc(1);  check("t1_busy_c1", 32'(bus.Busy), 32'd0);
      wait_cyc(2);  check("t1_busy_c2", 32'(bus.Busy), 32'd1);
                    check("t1_grant_c2", 32'(bus.Grant_Idx), 32'd0);
      wait_cyc(11); check("t1_busy_c11", 32'(bus.Busy), 32'd1);
                    check("t1_press_c11", 32'(bus.Press_Pulse), 32'd0);
      wait_cyc(12); check("t1_press_c12", 32'(bus.Press_Pulse), 32'b0001);
                    check("t1_busy_c12", 32'(bus.Busy), 32'd0);
                    check("t1_led_c12", 32'(bus.LED_Out), 32'b0001);
      wait_cyc(13); check("t1_press_c13", 32'(bus.Press_Pulse), 32'd0);
                    check("t1_led_c13", 32'(bus.LED_Out), 32'b0001);

      // two keys at once: key 1 then key 3
      do_reset();
      start_test();
      drive_at(0, 4'b1010, 4'b0000);
      wait_cyc(12); check("t2_press_c12", 32'(bus.Press_Pulse), 32'b0010);
      wait_cyc(13); check("t2_grant_c13", 32'(bus.Grant_Idx), 32'd3);
      wait_cyc(23); check("t2_press_c23", 32'(bus.Press_Pulse), 32'b1000);
      wait_cyc(24); check("t2_led_c24", 32'(bus.LED_Out), 32'b1010);

      // press then release on key 2
      do_reset();
      start_test();
      drive_at(0, 4'b0100, 4'b0000);
      drive_at(5, 4'b0000, 4'b0100);
      wait_cyc(12); check("t3_press_c12", 32'(bus.Press_Pulse), 32'b0100);
`ifdef KEY_SCHED_RELEASE_EN
      wait_cyc(13); check("t3_busy_c13", 32'(bus.Busy), 32'd1);
      wait_cyc(23); check("t3_release_c23", 32'(bus.Release_Pulse), 32'b0100);
`else
      wait_cyc(13); check("t3_busy_c13", 32'(bus.Busy), 32'd0);
      wait_cyc(23); check("t3_release_c23", 32'(bus.Release_Pulse), 32'd0);
`endif
      check("t3_press_c23", 32'(bus.Press_Pulse), 32'd0);

      // fairness: after key 2, key 3 beats key 0
      do_reset();
      start_test();
      drive_at(0, 4'b0100, 4'b0000);
      drive_at(5, 4'b1001, 4'b0000);
      wait_cyc(12); check("t4_press_c12", 32'(bus.Press_Pulse), 32'b0100);
      wait_cyc(23); check("t4_press_c23", 32'(bus.Press_Pulse), 32'b1000);
      wait_cyc(34); check("t4_press_c34", 32'(bus.Press_Pulse), 32'b0001);
      wait_cyc(35); check("t4_led_c35", 32'(bus.LED_Out), 32'b1101);

      // merge and re-queue on key 0
      do_reset();
      start_test();
      drive_at(0, 4'b0001, 4'b0000);
      drive_at(1, 4'b0001, 4'b0000);
      drive_at(6, 4'b0001, 4'b0000);
      wait_cyc(12); check("t5_press_c12", 32'(bus.Press_Pulse), 32'b0001);
      wait_cyc(23); check("t5_press_c23", 32'(bus.Press_Pulse), 32'b0001);
      wait_cyc(24); check("t5_led_c24", 32'(bus.LED_Out), 32'b0000);
      wait_cyc(34); check("t5_busy_c34", 32'(bus.Busy), 32'd0);
                    check("t5_press_c34", 32'(bus.Press_Pulse), 32'd0);

      // reset in the middle of a window with another key pending
      do_reset();
      start_test();
      drive_at(0, 4'b0110, 4'b0000);
      while (cyc - base < 7) begin
         @(posedge clk);
         #1;
      end
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      wait_cyc(40);
      check("t6_busy", 32'(bus.Busy), 32'd0);
      check("t6_led", 32'(bus.LED_Out), 32'd0);
      check("t6_press", 32'(bus.Press_Pulse), 32'd0);

      // randomized edges, occasional reset
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         logic [3:0] h;
         logic [3:0] l;
         @(posedge clk);
         #1;
         for (int b = 0; b < 4; b++) begin
            h[b] = ($urandom_range(0, 39) == 0);
            l[b] = ($urandom_range(0, 39) == 0);
         end
         bus.H2L_Sig = h;
         bus.L2H_Sig = l;
         if ($urandom_range(0, 1499) == 0) begin
            rstn = 1'b0;
            #2 rstn = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      bus.H2L_Sig = '0;
      bus.L2H_Sig = '0;
      repeat (200) @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_debounce_scheduler.md
# key_debounce_scheduler

Shares one millisecond-delay timer among four key channels. Each channel's H2L/L2H edge pulses come from the key edge detectors and are queued as pending events. A round-robin scheduler services one event at a time through a fixed debounce delay, then emits a one-cycle debounced pulse and toggles that channel's LED output. It sits between the per-key edge detectors and the LED/application logic, and replaces four independent delay counters with one.

## Interface
- T1MS, 16'd49_999: terminal count of the 1 ms prescaler (CLK cycles per ms minus 1; 50 MHz)
- DELAY_MS, 4'd10: debounce window in ms per serviced event; legal 1..15
- CLK  input  1  system clock, rising edge
- RSTn  input  1  reset, asynchronous, active-low
- H2L_Sig  input  4  per-key falling-edge (press) pulse, one cycle wide
- L2H_Sig  input  4  per-key rising-edge (release) pulse, one cycle wide
- Press_Pulse  output  4  one-cycle debounced press indication, one-hot
- Release_Pulse  output  4  one-cycle debounced release indication, one-hot (feature-gated)
- LED_Out  output  4  per-key toggle state, flips on each debounced press
- Busy  output  1  high while an event is being timed
- Grant_Idx  output  2  index of key being (or last) serviced

## Operation
- Pending flags: PendP[k] set by H2L_Sig[k]; PendR[k] set by L2H_Sig[k]. Flags are sticky; repeated events on an already-pending flag merge into one.
- Set beats clear: an edge arriving in the same cycle its flag is cleared by a grant leaves the flag set.
- FSM, two states:
  - IDLE: if any flag is set, select a key round-robin. The search starts at (Grant_Idx+1) mod 4. A key qualifies if PendP or PendR is set. Within the selected key, press takes priority over release. On selection: register Grant_Idx and the event type, clear that one flag, zero both counters, go to WAIT.
  - WAIT: Count1 runs 0..T1MS and wraps. Count_MS increments on each wrap. When Count_MS reaches DELAY_MS-1 and Count1==T1MS, go to IDLE. At that same edge, register Press_Pulse[Grant_Idx]=1 and flip LED_Out[Grant_Idx] for a press event, or register Release_Pulse[Grant_Idx]=1 for a release event.
- Edges on the key currently in WAIT set its flag and are serviced in a later slot; the window does not restart.
- Busy=1 exactly while the state is WAIT.
- Counters: Count1 16 bit, Count_MS 4 bit; both held at 0 in IDLE.

## Timing
- Reset values: Press_Pulse=0, Release_Pulse=0, LED_Out=0, Busy=0. Grant_Idx=2'd3, so key 0 wins first. All flags, counters and the FSM are cleared (FSM=IDLE).
- Reset mid-WAIT: the event is abandoned, no pulse is produced, and all pending flags are lost.
- Latency from an idle scheduler: edge pulse in cycle 0 → flag set at edge 1 → grant at edge 2 → output pulse high during cycle 2+DELAY_MS*(T1MS+1).
- Back-to-back service: IDLE lasts exactly one cycle between events. The next grant occurs at the edge that ends the pulse cycle.
- Throughput: one event per DELAY_MS*(T1MS+1)+1 cycles.
- Output pulses are exactly one cycle wide. At most one bit of Press_Pulse|Release_Pulse is set in any cycle.

## Configuration
- KEY_SCHED_RELEASE_EN defined:
  - L2H events are queued and serviced, consuming a full window each.
  - Release_Pulse is generated as described.
- KEY_SCHED_RELEASE_EN undefined:
  - L2H_Sig is ignored and the PendR flags are not built.
  - Release_Pulse is tied to 4'b0.
  - Only presses occupy the timer.

## Test plan
Use T1MS=4, DELAY_MS=2, so each window is 10 cycles.
- Reset, then H2L_Sig=4'b0001 in cycle 0 → Busy high in cycles 2..11; Press_Pulse=4'b0001 in cycle 12 only; LED_Out=4'b0001 from cycle 12.
- H2L_Sig=4'b1010 in cycle 0 → key 1 is serviced first (pulse in cycle 12), then key 3 (pulse in cycle 23); LED_Out ends at 4'b1010.
- With KEY_SCHED_RELEASE_EN: H2L[2] in cycle 0, L2H[2] in cycle 5 → Press_Pulse[2] in cycle 12, Release_Pulse[2] in cycle 23. Without the macro: only the press pulse, and Busy drops after cycle 12.
- Round-robin fairness: after key 2 is serviced, pending presses on keys 0 and 3 → key 3 is serviced before key 0.
- Merge and re-queue: H2L[0] in cycles 0 and 1, plus H2L[0] again in cycle 6 (during WAIT) → exactly two Press_Pulse[0] pulses (cycles 12 and 23); LED_Out[0] returns to 0.
- RSTn low in cycle 7 with key 1 in WAIT and key 2 pending → after release of reset there are no pulses, LED_Out=0 and Busy=0.
